// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that shares one 32-bit alu between two
// valid/ready requesters. One operation in flight; result is held until the
// owning requester accepts it.

// alu: 32-bit combinational ALU.
// f[2] inverts b and supplies the carry-in; f[1:0] selects and/or/sum/slt.
module alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  f,
    output logic [31:0] y,
    output logic        zero
);
    logic [31:0] bb;
    logic [31:0] s;

    // Operand conditioning and function select
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        bb = f[2] ? ~b : b;
        s  = a + bb + {31'd0, f[2]};
        y  = '0;
        case (f[1:0])
            2'b00:   y = a & bb;
            2'b01:   y = a | bb;
            2'b10:   y = s;
            default: y = {31'd0, s[31]};
        endcase
    end

    assign zero = (y == 32'd0);
endmodule

module alu_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_f,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_f,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_y,
    output logic        rsp_zero
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state, state_nx;
    logic        prio;          // requester that wins a tie
    logic        own;           // requester whose operation is in flight
    logic [2:0]  f_r;
    logic [31:0] a_r, b_r;
    logic [31:0] y_r;
    logic        z_r;
    logic [31:0] alu_y;
    logic        alu_zero;
    logic        take0, take1;

    // The ALU only ever sees registered operands.
    alu u_alu (
        .a    (a_r),
        .b    (b_r),
        .f    (f_r),
        .y    (alu_y),
        .zero (alu_zero)
    );

    // Grant: only in IDLE; the prioritised requester blocks the other on a tie.
    assign req0_ready = (state == IDLE) && !reset && !(req1_valid && prio);
    assign req1_ready = (state == IDLE) && !reset && !(req0_valid && !prio);
    assign take0      = req0_valid && req0_ready;
    assign take1      = req1_valid && req1_ready;

    assign rsp_y    = y_r;
    assign rsp_zero = z_r;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state and response-valid decode
    always_comb begin
        state_nx   = state;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (state)
            IDLE: if (take0 || take1) state_nx = EXEC;
            EXEC: state_nx = RESP;
            RESP: begin
                rsp0_valid = !own;
                rsp1_valid = own;
                if (own ? rsp1_ready : rsp0_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture on grant, result capture after one execute cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio <= 1'b0;
            own  <= 1'b0;
            f_r  <= '0;
            a_r  <= '0;
            b_r  <= '0;
            y_r  <= '0;
            z_r  <= 1'b0;
        end else begin
            if (take0) begin
                f_r  <= req0_f;
                a_r  <= req0_a;
                b_r  <= req0_b;
                own  <= 1'b0;
                prio <= 1'b1;
            end else if (take1) begin
                f_r  <= req1_f;
                a_r  <= req1_a;
                b_r  <= req1_b;
                own  <= 1'b1;
                prio <= 1'b0;
            end
            if (state == EXEC) begin
                y_r <= alu_y;
                z_r <= alu_zero;
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a
// transaction-level reference (arithmetic result, tie-break rule, latency).
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]  req0_f, req1_f;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp_y;
    logic        rsp_zero;

    int total = 0;
    int bad   = 0;
    bit m_prio = 1'b0;

    alu_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_f     (req0_f),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_f     (req1_f),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_y      (rsp_y),
        .rsp_zero   (rsp_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference ALU: {zero, y} straight from the function-code meanings.
    function automatic logic [32:0] ref_alu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] y;
        logic [31:0] t;
        case (f)
            3'b000: y = a & b;
            3'b001: y = a | b;
            3'b010: y = a + b;
            3'b011: begin t = a + b; y = {31'd0, t[31]}; end
            3'b100: y = a & ~b;
            3'b101: y = a | ~b;
            3'b110: y = a - b;
            default: begin t = a - b; y = {31'd0, t[31]}; end
        endcase
        return {(y == 32'd0), y};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction starting in IDLE. Checks grant, latency,
    // back-pressure stability for 'hold' cycles and completion.
    task automatic do_op(input bit v0, input logic [2:0] f0, input logic [31:0] a0, input logic [31:0] b0,
                         input bit v1, input logic [2:0] f1, input logic [31:0] a1, input logic [31:0] b1,
                         input int hold, input bit keep);
        int          w;
        logic [32:0] exp;
        req0_valid = v0; req0_f = f0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_f = f1; req1_a = a1; req1_b = b1;
        #1;
        check("grant_req0_ready", req0_ready, !(v1 && m_prio));
        check("grant_req1_ready", req1_ready, !(v0 && !m_prio));
        w   = (v0 && v1) ? int'(m_prio) : (v1 ? 1 : 0);
        exp = (w == 1) ? ref_alu(f1, a1, b1) : ref_alu(f0, a0, b0);
        tick();
        if (!keep) begin
            if (w == 0) req0_valid = 1'b0;
            else        req1_valid = 1'b0;
        end
        check("exec_rsp0_valid", rsp0_valid, 0);
        check("exec_rsp1_valid", rsp1_valid, 0);
        check("exec_readies", {req0_ready, req1_ready}, 0);
        tick();
        for (int i = 0; i <= hold; i++) begin
            check("rsp0_valid", rsp0_valid, (w == 0));
            check("rsp1_valid", rsp1_valid, (w == 1));
            check("rsp_y", rsp_y, exp[31:0]);
            check("rsp_zero", rsp_zero, exp[32]);
            check("resp_readies", {req0_ready, req1_ready}, 0);
            if (i < hold) begin
                if (w == 0) rsp1_ready = 1'($urandom);
                else        rsp0_ready = 1'($urandom);
                tick();
            end
        end
        if (w == 0) begin rsp0_ready = 1'b1; rsp1_ready = 1'($urandom); end
        else        begin rsp1_ready = 1'b1; rsp0_ready = 1'($urandom); end
        tick();
        check("done_rsp_valids", {rsp0_valid, rsp1_valid}, 0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        m_prio = (w == 0);
    endtask

    // A cycle with no request: both ready, nothing happens.
    task automatic idle_cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        check("idle_readies", {req0_ready, req1_ready}, 2'b11);
        tick();
        check("idle_rsp_valids", {rsp0_valid, rsp1_valid}, 0);
    endtask

    // Start a req0 operation, then reset in EXEC (stages=1) or RESP (stages=2).
    task automatic reset_mid(input int stages);
        req0_valid = 1'b1; req0_f = 3'b010; req0_a = 32'd1; req0_b = 32'd1;
        req1_valid = 1'b0;
        tick();
        req0_valid = 1'b0;
        if (stages == 2) begin
            tick();
            check("pre_reset_rsp0_valid", rsp0_valid, 1);
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        reset = 1'b1;
        #1;
        check("midrst_readies", {req0_ready, req1_ready}, 0);
        check("midrst_rsp_valids", {rsp0_valid, rsp1_valid}, 0);
        check("midrst_rsp_y", rsp_y, 0);
        check("midrst_rsp_zero", rsp_zero, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        reset = 1'b0;
        m_prio = 1'b0;
        tick();
    endtask

    initial begin
        logic [2:0]  rf0, rf1;
        logic [31:0] ra0, rb0, ra1, rb1;
        bit          rv0, rv1;

        reset = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_f = '0; req0_a = '0; req0_b = '0;
        req1_f = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #12;
        check("rst_readies", {req0_ready, req1_ready}, 0);
        check("rst_rsp_valids", {rsp0_valid, rsp1_valid}, 0);
        check("rst_rsp_y", rsp_y, 0);
        check("rst_rsp_zero", rsp_zero, 0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        reset = 1'b0;
        tick();

        // Single add on channel 0
        do_op(1, 3'b010, 32'd2, 32'd3, 0, 3'b000, 32'd0, 32'd0, 0, 0);
        // Tie with prio back at 0 after the first op? prio is 1 now; re-reset for a clean tie
        reset_mid(1);
        do_op(1, 3'b110, 32'd7, 32'd7, 1, 3'b001, 32'hF0, 32'h0F, 0, 0);
        do_op(0, 3'b110, 32'd7, 32'd7, 1, 3'b001, 32'hF0, 32'h0F, 0, 0);
        // Both held valid: strict alternation
        for (int i = 0; i < 4; i++)
            do_op(1, 3'b010, 32'd10 + i, 32'd1, 1, 3'b110, 32'd100, 32'd1 + i, 0, 1);
        idle_cycle();
        // Make req1 the prioritised one, then back-pressure its response
        do_op(1, 3'b000, 32'hFF00, 32'h0FF0, 0, 3'b000, 0, 0, 1, 0);
        do_op(1, 3'b001, 32'h1, 32'h2, 1, 3'b111, 32'hFFFF_FFFF, 32'd1, 5, 0);
        do_op(1, 3'b001, 32'h1, 32'h2, 0, 3'b000, 0, 0, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            rv0 = 1'($urandom); rv1 = 1'($urandom);
            rf0 = 3'($urandom); rf1 = 3'($urandom);
            ra0 = $urandom; rb0 = ($urandom_range(0, 3) == 0) ? ra0 : $urandom;
            ra1 = $urandom_range(0, 8); rb1 = $urandom_range(0, 8);
            if (!rv0 && !rv1) idle_cycle();
            else do_op(rv0, rf0, ra0, rb0, rv1, rf1, ra1, rb1, $urandom_range(0, 3), 0);
        end

        // Reset while in EXEC, then in RESP; req0 must win the tie afterwards
        do_op(0, 3'b000, 0, 0, 1, 3'b010, 32'd4, 32'd4, 0, 0);
        reset_mid(1);
        reset_mid(2);
        do_op(1, 3'b010, 32'd20, 32'd22, 1, 3'b010, 32'd1, 32'd1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one instance of the 32-bit `alu` (ports `a`, `b`, `f[2:0]`, `y`, `zero`) between two requesters. Each requester has a valid/ready request channel and a valid/ready response channel. The block grants the ALU with round-robin priority, registers the operands, captures the result and holds it until the owning requester accepts it. It sits between the two client blocks and the ALU and is the ALU's only driver. Operation is one transaction at a time, with no pipelining.

## Interface
- Parameters: none. Datapath width is fixed at 32 by `alu`; `f` encoding is passed through unmodified.
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req0_valid`, `req1_valid`  in  1  requester n presents an operation
- `req0_ready`, `req1_ready`  out  1  arbiter accepts requester n's operation this cycle
- `req0_f`, `req1_f`  in  3  ALU function code for requester n
- `req0_a`, `req1_a`, `req0_b`, `req1_b`  in  32  operands for requester n
- `rsp0_valid`, `rsp1_valid`  out  1  result for requester n available
- `rsp0_ready`, `rsp1_ready`  in  1  requester n accepts result
- `rsp_y`  out  32  result, shared by both response channels
- `rsp_zero`  out  1  zero flag, shared by both response channels

## Operation
- Internal state:
  - FSM `state` ∈ {IDLE, EXEC, RESP}
  - priority bit `prio`
  - owner bit `own`
  - operand registers `f_r[2:0]`, `a_r[31:0]`, `b_r[31:0]`
  - result registers `y_r[31:0]`, `z_r`
- The ALU is driven only from `f_r`, `a_r`, `b_r`, never directly from requester inputs.
- Grant, combinational, only in IDLE and only while `reset`=0:
  - `req0_ready = IDLE & !(req1_valid & prio)`
  - `req1_ready = IDLE & !(req0_valid & !prio)`
  - In all other states both readies are 0.
- Transfer occurs on `reqn_valid & reqn_ready`. At most one transfer per cycle, guaranteed by the grant equations.
- IDLE → EXEC on a transfer:
  - latch `f_r`, `a_r`, `b_r` from the granted requester
  - `own` = granted index
  - `prio` = !granted index (the requester just served gets lowest priority)
- IDLE with no valid request: stay in IDLE; `prio` unchanged.
- EXEC → RESP unconditionally: `y_r` ← `alu.y`, `z_r` ← `alu.zero`.
- RESP:
  - `rsp{own}_valid` = 1; the other response valid = 0
  - `rsp_y` = `y_r`, `rsp_zero` = `z_r`
  - on `rsp{own}_ready` → IDLE
  - the other channel's `rsp_ready` is ignored
- `rsp_y` and `rsp_zero` are driven from `y_r` and `z_r` in all states. They are only meaningful while a response valid is high.
- Requesters must hold valid and payload stable until ready. The arbiter does not re-sample payload after transfer.
- Undefined `f` codes are forwarded unchanged; the response is whatever `alu` produces.

## Timing
- Reset (async): `state`=IDLE, `prio`=0, `own`=0, all registers 0.
  - While `reset`=1: `req0_ready` = `req1_ready` = 0, `rsp0_valid` = `rsp1_valid` = 0, `rsp_y` = 0, `rsp_zero` = 0.
- Latency, with transfer at rising edge k:
  - edge k: IDLE→EXEC
  - edge k+1: result captured, EXEC→RESP
  - `rspn_valid` is high from edge k+1 until the edge where `rspn_ready` is sampled 1
- If `rspn_ready` is already 1 when valid rises, the response completes at edge k+2 and the next request is accepted at edge k+3 at the earliest.
- Peak throughput is 1 operation per 3 cycles.
- Simultaneous valid on both channels in IDLE: the requester indicated by `prio` wins; the loser's ready is 0.
- If both are held valid continuously, grants alternate strictly.
- Back-pressure: RESP is held indefinitely while `rsp{own}_ready` = 0. `y_r`, `z_r` and the valid stay stable; both request readies stay 0.
- Reset mid-operation, in EXEC or RESP: the pending operation and result are discarded. Outputs return to reset values immediately, without waiting for a clock edge.

## Test plan
- Reset, then `req0` valid with f=010, a=2, b=3 → `req0_ready`=1 in that cycle. `rsp0_valid` rises after 2 edges with `rsp_y`=5, `rsp_zero`=0. `rsp1_valid` stays 0 throughout.
- Same cycle after reset: `req0` (f=110, a=7, b=7) and `req1` (f=001, a=F0, b=0F) → `req0` is served first with `rsp_y`=0, `rsp_zero`=1. `req1` is served next with `rsp_y`=FF, `rsp_zero`=0.
- Both requesters held valid for 4 operations → grant order 0,1,0,1. Each `rspn_valid` appears only on its owner's channel.
- `req1` with f=111, a=FFFFFFFF, b=1, and `rsp1_ready` held 0 for 5 cycles → `rsp1_valid`=1 with `rsp_y`=1 stable for all 5 cycles. `req0_ready` stays 0 while `req0` is valid. The response completes on the cycle `rsp1_ready` is raised.
- Assert `reset` while in EXEC, then again while in RESP → `rspn_valid` and both readies go 0 immediately. After release: IDLE, and `req0` wins a simultaneous request (`prio`=0).
